bist_seq_checker: RTL and testbench
===================================

Name: bist_seq_checker

Overview:
- Parametrised next-generation FSM built-in self-test (BIST) engine.
- Holds a vector memory of {drive, expected-state} words and replays a programmable window of it into a DUT state machine.
- Compares the DUT state on every step and reports pass/fail, fail count, and the first-fault record.
- Sits between the JTAG-side config/data registers and the DUT FSM. It adds run modes, abort, a busy/done handshake and wrap-around addressing.

Parameters:
- STATE_W, 4, DUT state width and expected-field width.
- DRIVE_W, 4, DUT drive (input stimulus) width.
- MEMSIZE, 128, vector depth; must be a power of two.
- ADDR_W, $clog2(MEMSIZE), vector address width.
- CNT_W, 8, width of the fail and loop counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  pulse: begin a test; sampled in IDLE only.
- abort_i  in  1  pulse: stop the current test.
- mode_i  in  2  0=STOP_ON_FAIL, 1=LOG_ALL, 2=LOOP, 3=reserved (treated as STOP_ON_FAIL); latched at start.
- start_addr_i  in  ADDR_W  first vector address; latched at start.
- len_i  in  ADDR_W+1  vector count, 0..MEMSIZE; latched at start.
- state_i  in  STATE_W  DUT current state.
- drive_o  out  DRIVE_W  stimulus to DUT.
- mem_we_i  in  1  vector write strobe.
- mem_addr_i  in  ADDR_W  vector write/read address.
- mem_data_i  in  DRIVE_W+STATE_W  write data, {drive, expected}.
- mem_data_o  out  DRIVE_W+STATE_W  read data at mem_addr_i (1-cycle latency, valid while idle).
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at test end.
- pass_o  out  1  result of the last test.
- aborted_o  out  1  last test ended by abort.
- fail_cnt_o  out  CNT_W  mismatches in the last test, saturating.
- loop_cnt_o  out  CNT_W  completed passes in LOOP mode, saturating.
- step_o  out  ADDR_W+1  current vector index.
- flt_addr_o  out  ADDR_W  address of the first failing vector.
- flt_prev_o  out  STATE_W  DUT state before the failing step.
- flt_obs_o  out  STATE_W  observed state.
- flt_exp_o  out  STATE_W  expected state.
- flt_drive_o  out  DRIVE_W  drive applied on the failing step.

Behaviour:
- Reset:
  - All outputs 0; pass_o=0; FSM returns to IDLE.
  - Reset asserted mid-test abandons the test with no done_o pulse.
  - Vector memory contents are not reset.
- FSM states: IDLE, PRIME, RUN, DRAIN, FIN.
- IDLE -> PRIME on start_i:
  - Latch mode, start address and length.
  - Clear fail_cnt, loop_cnt, step and the fault record.
- IDLE with start_i and len_i=0 -> FIN directly: pass_o=1, no vectors driven.
- PRIME (1 cycle): present address start_addr to the synchronous-read RAM.
- RUN, cycle k (k=0..len-1):
  - drive_o = drive field of vector k; address of vector k+1 issued.
  - Expected field of vector k registered as exp_ff.
  - prev_ff <= state_i.
- Compare:
  - In RUN cycle k>=1 and in DRAIN, state_i is compared to exp_ff of vector k-1. This is a 1-cycle DUT latency: the DUT updates on the edge after drive.
  - The last vector's compare happens in DRAIN (1 cycle). Total test = len+2 cycles from start to FIN.
- Addressing: vector address = (start_addr + k) mod MEMSIZE; wrap is natural because MEMSIZE is a power of two.
- On mismatch:
  - fail_cnt increments, saturating at 2^CNT_W-1.
  - On the first mismatch only, the fault record is captured: address, prev_ff, state_i, exp_ff, drive of the failing vector.
- STOP_ON_FAIL: the first mismatch goes -> FIN immediately; remaining vectors are not driven.
- LOG_ALL: runs all len vectors regardless of mismatches.
- LOOP:
  - After DRAIN with no mismatch, loop_cnt increments (saturating) -> PRIME, restarting at start_addr.
  - Any mismatch -> FIN.
- abort_i:
  - In PRIME/RUN/DRAIN -> FIN with aborted_o=1 and pass_o=0. In LOOP mode, pass_o=1 when fail_cnt=0.
  - abort_i is ignored in IDLE and FIN.
- FIN (1 cycle):
  - done_o=1, pass_o=(fail_cnt==0) except as above -> IDLE.
  - Results hold until the next start.
- Idle/busy outputs:
  - busy_o=1 in PRIME/RUN/DRAIN/FIN.
  - drive_o=0 whenever not in RUN.
  - start_i while busy is ignored.
- Memory:
  - mem_we_i while busy_o=1 is ignored: vectors are protected during a test.
  - Write has priority over the idle read address; mem_data_o is the old data (read-first).
- Simultaneous start_i and abort_i in IDLE: start wins and abort is ignored.

Decomposition:
- bist_pkg:
  - mode enum (STOP_ON_FAIL, LOG_ALL, LOOP).
  - FSM state enum.
  - Fault-record struct {addr, prev, obs, exp, drive}, parametrised by width localparams.
- Sub-module bist_vec_ram: single-port synchronous-read, read-first RAM of MEMSIZE x (DRIVE_W+STATE_W).

Test Plan:
- LOG_ALL all-pass, 5 vectors:
  - Stimulus: vectors at 0..4 with a DUT model matching; start_addr=0, len=5.
  - Required: done_o at cycle 7 after start, pass_o=1, fail_cnt_o=0, drive_o sequence matches memory.
- STOP_ON_FAIL, wrong transition on vector 3:
  - Stimulus: DUT model forced to give state 0xA where 0x5 is expected.
  - Required: done_o, pass_o=0, fail_cnt_o=1, flt_addr_o=3, flt_obs_o=0xA, flt_exp_o=0x5; vector 4 is never driven.
- LOG_ALL wrap-around:
  - Stimulus: start_addr=126, len=4, mismatches on addresses 127 and 1.
  - Required: addresses walk 126,127,0,1; fail_cnt_o=2; flt_addr_o=127.
- LOOP:
  - Stimulus: len=3, matching DUT, abort_i after 4 full passes.
  - Required: loop_cnt_o=4, aborted_o=1, pass_o=1, drive_o=0 after FIN.
- Reset and protection:
  - Stimulus: rst mid-RUN, then mem_we_i during a running test.
  - Required: after rst, busy_o=0 and no done_o; the write during the test is ignored, checked by idle readback of mem_data_o.
- Edge cases:
  - Stimulus: len_i=0 start; separately, start_i and abort_i together in IDLE.
  - Required: len 0 gives done_o next cycle with pass_o=1; simultaneous start/abort starts a normal test.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types for the FSM BIST engine: run modes, controller states and the
// first-fault record. The width localparams are the engine's default sizing.
package bist_pkg;

  localparam int BIST_STATE_W = 4;
  localparam int BIST_DRIVE_W = 4;
  localparam int BIST_MEMSIZE = 128;
  localparam int BIST_ADDR_W  = $clog2(BIST_MEMSIZE);
  localparam int BIST_CNT_W   = 8;

  typedef enum logic [1:0] {
    MODE_STOP_ON_FAIL = 2'd0,
    MODE_LOG_ALL      = 2'd1,
    MODE_LOOP         = 2'd2
  } bist_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } bist_state_e;

  typedef struct packed {
    logic [BIST_ADDR_W-1:0]  addr;
    logic [BIST_STATE_W-1:0] prev;
    logic [BIST_STATE_W-1:0] obs;
    logic [BIST_STATE_W-1:0] exp;
    logic [BIST_DRIVE_W-1:0] drive;
  } bist_flt_t;

  // The reserved encoding behaves as stop-on-fail.
  function automatic bist_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_LOG_ALL;
      2'd2:    return MODE_LOOP;
      default: return MODE_STOP_ON_FAIL;
    endcase
  endfunction

endpackage

// File: rtl/bist_vec_ram.sv
// Single-port vector store: synchronous read, read-first on a write cycle.
// Contents are deliberately not reset.
module bist_vec_ram #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bist_seq_checker.sv
// FSM BIST engine: replays a window of {drive, expected} vectors into a DUT
// state machine and checks the DUT state one cycle after each drive.
module bist_seq_checker
  import bist_pkg::*;
#(
  parameter int STATE_W = BIST_STATE_W,
  parameter int DRIVE_W = BIST_DRIVE_W,
  parameter int MEMSIZE = BIST_MEMSIZE,
  parameter int ADDR_W  = $clog2(MEMSIZE),
  parameter int CNT_W   = BIST_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [1:0]                 mode_i,
  input  logic [ADDR_W-1:0]          start_addr_i,
  input  logic [ADDR_W:0]            len_i,
  input  logic [STATE_W-1:0]         state_i,
  output logic [DRIVE_W-1:0]         drive_o,
  input  logic                       mem_we_i,
  input  logic [ADDR_W-1:0]          mem_addr_i,
  input  logic [DRIVE_W+STATE_W-1:0] mem_data_i,
  output logic [DRIVE_W+STATE_W-1:0] mem_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       aborted_o,
  output logic [CNT_W-1:0]           fail_cnt_o,
  output logic [CNT_W-1:0]           loop_cnt_o,
  output logic [ADDR_W:0]            step_o,
  output logic [ADDR_W-1:0]          flt_addr_o,
  output logic [STATE_W-1:0]         flt_prev_o,
  output logic [STATE_W-1:0]         flt_obs_o,
  output logic [STATE_W-1:0]         flt_exp_o,
  output logic [DRIVE_W-1:0]         flt_drive_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   STEP_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  bist_state_e               state_ff, state_nxt;
  bist_mode_e                mode_ff;
  logic [ADDR_W-1:0]         start_ff, run_addr_ff, addr_ff, ram_addr;
  logic [ADDR_W:0]           len_ff, step_ff;
  logic [STATE_W-1:0]        exp_ff, prev_ff, vec_exp;
  logic [DRIVE_W-1:0]        drv_ff, vec_drive;
  logic [CNT_W-1:0]          fail_cnt_ff, loop_cnt_ff;
  bist_flt_t                 flt_ff;
  logic                      pass_ff, aborted_ff, rd_valid_ff, ram_we;
  logic                      cmp_en, mismatch, stop_now, last_vec, fail_any;
  logic [DRIVE_W+STATE_W-1:0] ram_rdata;

  bist_vec_ram #(
    .DEPTH (MEMSIZE),
    .ADDR_W(ADDR_W),
    .DATA_W(DRIVE_W + STATE_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(mem_data_i),
    .rdata(ram_rdata)
  );

  assign vec_drive = ram_rdata[DRIVE_W+STATE_W-1:STATE_W];
  assign vec_exp   = ram_rdata[STATE_W-1:0];

  // The DUT answers one cycle after a drive, so RUN step k checks vector k-1
  // and DRAIN checks the last vector.
  always_comb begin
    cmp_en   = ((state_ff == ST_RUN) && (step_ff != '0)) || (state_ff == ST_DRAIN);
    mismatch = cmp_en && (state_i != exp_ff);
    stop_now = mismatch && (mode_ff != MODE_LOG_ALL);
    last_vec = (step_ff + STEP_ONE) == len_ff;
    fail_any = mismatch || (fail_cnt_ff != '0);
  end

  always_comb begin
    state_nxt = state_ff;
    case (state_ff)
      ST_IDLE:  if (start_i) state_nxt = (len_i == '0) ? ST_FIN : ST_PRIME;
      ST_PRIME: state_nxt = abort_i ? ST_FIN : ST_RUN;
      ST_RUN: begin
        if (abort_i || stop_now) state_nxt = ST_FIN;
        else if (last_vec)       state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_i || mismatch || (mode_ff != MODE_LOOP)) state_nxt = ST_FIN;
        else                                               state_nxt = ST_PRIME;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake: start_i is a one-cycle request taken only in IDLE; busy_o is
  // high from the following cycle until the single done_o cycle inclusive.
  // A failing compare in a stopping mode suppresses the vector it overlaps.
  always_comb begin
    busy_o     = (state_ff != ST_IDLE);
    done_o     = (state_ff == ST_FIN);
    drive_o    = ((state_ff == ST_RUN) && !stop_now) ? vec_drive : '0;
    ram_we     = mem_we_i && (state_ff == ST_IDLE);
    ram_addr   = (state_ff == ST_IDLE) ? mem_addr_i : run_addr_ff;
    mem_data_o = rd_valid_ff ? ram_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_ff    <= ST_IDLE;
      mode_ff     <= MODE_STOP_ON_FAIL;
      start_ff    <= '0;
      run_addr_ff <= '0;
      addr_ff     <= '0;
      len_ff      <= '0;
      step_ff     <= '0;
      exp_ff      <= '0;
      prev_ff     <= '0;
      drv_ff      <= '0;
      fail_cnt_ff <= '0;
      loop_cnt_ff <= '0;
      flt_ff      <= '0;
      pass_ff     <= 1'b0;
      aborted_ff  <= 1'b0;
      rd_valid_ff <= 1'b0;
    end else begin
      state_ff    <= state_nxt;
      rd_valid_ff <= (state_ff == ST_IDLE);
      case (state_ff)
        ST_IDLE: if (start_i) begin
          mode_ff     <= decode_mode(mode_i);
          start_ff    <= start_addr_i;
          run_addr_ff <= start_addr_i;
          len_ff      <= len_i;
          step_ff     <= '0;
          fail_cnt_ff <= '0;
          loop_cnt_ff <= '0;
          flt_ff      <= '0;
          aborted_ff  <= 1'b0;
          pass_ff     <= (len_i == '0);
        end
        ST_PRIME: run_addr_ff <= run_addr_ff + ADDR_ONE;
        ST_RUN: begin
          run_addr_ff <= run_addr_ff + ADDR_ONE;
          step_ff     <= step_ff + STEP_ONE;
          addr_ff     <= run_addr_ff - ADDR_ONE;
          exp_ff      <= vec_exp;
          drv_ff      <= vec_drive;
          prev_ff     <= state_i;
        end
        ST_DRAIN: if (state_nxt == ST_PRIME) begin
          run_addr_ff <= start_ff;
          step_ff     <= '0;
          if (loop_cnt_ff != '1) loop_cnt_ff <= loop_cnt_ff + CNT_ONE;
        end
        default: ;
      endcase
      if (mismatch) begin
        if (fail_cnt_ff != '1) fail_cnt_ff <= fail_cnt_ff + CNT_ONE;
        if (fail_cnt_ff == '0)
          flt_ff <= '{addr: addr_ff, prev: prev_ff, obs: state_i, exp: exp_ff, drive: drv_ff};
      end
      if ((state_ff != ST_IDLE) && (state_ff != ST_FIN) && (state_nxt == ST_FIN)) begin
        aborted_ff <= abort_i;
        pass_ff    <= !fail_any && (!abort_i || (mode_ff == MODE_LOOP));
      end
    end
  end

  assign pass_o      = pass_ff;
  assign aborted_o   = aborted_ff;
  assign fail_cnt_o  = fail_cnt_ff;
  assign loop_cnt_o  = loop_cnt_ff;
  assign step_o      = step_ff;
  assign flt_addr_o  = flt_ff.addr;
  assign flt_prev_o  = flt_ff.prev;
  assign flt_obs_o   = flt_ff.obs;
  assign flt_exp_o   = flt_ff.exp;
  assign flt_drive_o = flt_ff.drive;

endmodule

// File: tb/tb_bist_seq_checker.sv
// Directed bench for bist_seq_checker: table of whole-test records plus
// hand-written loop, reset and write-protection sequences.
module tb_bist_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0, abort_i = 1'b0, mem_we_i = 1'b0;
  logic [1:0] mode_i = '0;
  logic [6:0] start_addr_i = '0, mem_addr_i = '0;
  logic [7:0] len_i = '0, mem_data_i = '0;
  logic [3:0] state_i, drive_o;
  logic [7:0] mem_data_o, fail_cnt_o, loop_cnt_o, step_o;
  logic       busy_o, done_o, pass_o, aborted_o;
  logic [6:0] flt_addr_o;
  logic [3:0] flt_prev_o, flt_obs_o, flt_exp_o, flt_drive_o;

  bist_seq_checker dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .start_addr_i(start_addr_i), .len_i(len_i), .state_i(state_i), .drive_o(drive_o),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .aborted_o(aborted_o), .fail_cnt_o(fail_cnt_o), .loop_cnt_o(loop_cnt_o),
    .step_o(step_o), .flt_addr_o(flt_addr_o), .flt_prev_o(flt_prev_o),
    .flt_obs_o(flt_obs_o), .flt_exp_o(flt_exp_o), .flt_drive_o(flt_drive_o)
  );

  always #5 clk = ~clk;

  // DUT model: next state equals the applied drive, optionally corrupted.
  logic [3:0] dut_state = '0;
  logic [3:0] mask [16];
  always @(posedge clk) dut_state <= drive_o ^ mask[drive_o];
  assign state_i = dut_state;

  int checks = 0;
  int errors = 0;
  logic [3:0] hist [48];

  typedef struct packed {
    logic [1:0]       mode;
    logic [6:0]       saddr;
    logic [7:0]       len;
    logic             sa;
    logic [5:0][7:0]  vec;
    logic [7:0]       cyc;
    logic [7:0]       n_drv;
    logic             pass;
    logic [7:0]       fail;
    logic [6:0]       faddr;
    logic [15:0]      rec;
  } row_t;

  row_t rows [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic write_mem(input logic [6:0] a, input logic [7:0] d);
    mem_we_i = 1'b1; mem_addr_i = a; mem_data_i = d;
    @(negedge clk);
    mem_we_i = 1'b0;
  endtask

  task automatic launch(input logic [1:0] m, input logic [6:0] s, input logic [7:0] l, input logic ab);
    mode_i = m; start_addr_i = s; len_i = l; abort_i = ab; start_i = 1'b1;
  endtask

  // Cycle 0 is the first sample after the start edge; stops on done_o.
  task automatic run_to_done(input int we_at, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 48; i++) hist[i] = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start_i = 1'b0; abort_i = 1'b0;
      mem_we_i = (c == we_at);
      if (c == we_at) begin mem_addr_i = 7'd42; mem_data_i = 8'hFF; end
      hist[c] = drive_o;
      if (done_o) begin done_cyc = c; break; end
    end
    mem_we_i = 1'b0;
  endtask

  // vec literal lists vector 0 in the low byte; rec = {prev, obs, exp, drive}.
  function automatic row_t mk(input logic [1:0] m, input logic [6:0] s, input logic [7:0] l,
                              input logic ab, input logic [47:0] v, input logic [7:0] cyc,
                              input logic [7:0] n, input logic ps, input logic [7:0] fc,
                              input logic [6:0] fa, input logic [15:0] rec);
    row_t r;
    r.mode = m; r.saddr = s; r.len = l; r.sa = ab; r.vec = v; r.cyc = cyc;
    r.n_drv = n; r.pass = ps; r.fail = fc; r.faddr = fa; r.rec = rec;
    return r;
  endfunction

  initial begin
    int dc, lc, n;
    logic saw;
    for (int i = 0; i < 16; i++) mask[i] = '0;
    mask[5] = 4'hF; mask[6] = 4'h1; mask[12] = 4'h2;

    rows[0] = mk(2'd1, 7'd0,   8'd5, 1'b0, 48'h00_77_44_33_22_11, 8'd7, 8'd5, 1'b1, 8'd0, 7'd0,   16'h0000);
    rows[1] = mk(2'd0, 7'd0,   8'd6, 1'b0, 48'h99_77_55_33_22_11, 8'd6, 8'd4, 1'b0, 8'd1, 7'd3,   16'h3A55);
    rows[2] = mk(2'd1, 7'd126, 8'd4, 1'b0, 48'h00_00_CC_88_66_44, 8'd6, 8'd4, 1'b0, 8'd2, 7'd127, 16'h4766);
    rows[3] = mk(2'd3, 7'd0,   8'd6, 1'b0, 48'h99_77_55_33_22_11, 8'd6, 8'd4, 1'b0, 8'd1, 7'd3,   16'h3A55);
    rows[4] = mk(2'd0, 7'd5,   8'd0, 1'b0, 48'h0,                 8'd0, 8'd0, 1'b1, 8'd0, 7'd0,   16'h0000);
    rows[5] = mk(2'd1, 7'd40,  8'd3, 1'b1, 48'h00_00_00_33_22_11, 8'd5, 8'd3, 1'b1, 8'd0, 7'd0,   16'h0000);

    // Clock/reset: outputs are all zero while reset is held.
    repeat (3) @(negedge clk);
    check("rst busy", busy_o, 0);       check("rst done", done_o, 0);
    check("rst pass", pass_o, 0);       check("rst aborted", aborted_o, 0);
    check("rst fail_cnt", fail_cnt_o, 0); check("rst loop_cnt", loop_cnt_o, 0);
    check("rst step", step_o, 0);       check("rst drive", drive_o, 0);
    check("rst mem_data", mem_data_o, 0);
    check("rst flt", {flt_addr_o, flt_prev_o, flt_obs_o, flt_exp_o, flt_drive_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Idle write is read-first: the second write returns the first value.
    mem_addr_i = 7'd50;
    write_mem(7'd50, 8'h5A);
    mem_we_i = 1'b1; mem_data_i = 8'hA5;
    @(negedge clk);
    mem_we_i = 1'b0;
    check("read_first old", mem_data_o, 8'h5A);
    @(negedge clk);
    check("read_back new", mem_data_o, 8'hA5);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'(rows[r].len) && i < 6; i++)
        write_mem(7'(rows[r].saddr + i), rows[r].vec[i]);
      launch(rows[r].mode, rows[r].saddr, rows[r].len, rows[r].sa);
      run_to_done(-1, dc);
      check($sformatf("r%0d done_cyc", r), dc, rows[r].cyc);
      check($sformatf("r%0d pass", r), pass_o, rows[r].pass);
      check($sformatf("r%0d aborted", r), aborted_o, 0);
      check($sformatf("r%0d busy_in_fin", r), busy_o, 1);
      check($sformatf("r%0d fail_cnt", r), fail_cnt_o, rows[r].fail);
      check($sformatf("r%0d flt_addr", r), flt_addr_o, rows[r].faddr);
      check($sformatf("r%0d flt_rec", r), {flt_prev_o, flt_obs_o, flt_exp_o, flt_drive_o}, rows[r].rec);
      @(negedge clk);
      if (dc >= 0) hist[dc+1] = drive_o;
      check($sformatf("r%0d idle_busy", r), busy_o, 0);
      check($sformatf("r%0d idle_done", r), done_o, 0);
      check($sformatf("r%0d pass_hold", r), pass_o, rows[r].pass);
      n = int'(rows[r].n_drv);
      for (int i = 1; i <= n; i++)
        check($sformatf("r%0d drive%0d", r, i - 1), hist[i], rows[r].vec[i-1][7:4]);
      check($sformatf("r%0d drive_after", r), hist[n+1], 0);
    end

    // LOOP: four clean passes of three vectors, then abort.
    write_mem(7'd60, 8'h11); write_mem(7'd61, 8'h22); write_mem(7'd62, 8'h33);
    launch(2'd2, 7'd60, 8'd3, 1'b0);
    lc = -1; saw = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) saw = 1'b1;
      if (loop_cnt_o == 8'd4) begin lc = c; break; end
    end
    check("loop reach4 cyc", lc, 20);
    check("loop no early done", saw, 0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("loop done", done_o, 1);      check("loop aborted", aborted_o, 1);
    check("loop pass", pass_o, 1);      check("loop loop_cnt", loop_cnt_o, 4);
    check("loop fail_cnt", fail_cnt_o, 0); check("loop drive_fin", drive_o, 0);
    @(negedge clk);
    check("loop busy_after", busy_o, 0); check("loop drive_after", drive_o, 0);
    check("loop cnt_hold", loop_cnt_o, 4);

    // Reset mid-RUN abandons the test with no done pulse.
    write_mem(7'd40, 8'h11); write_mem(7'd41, 8'h22); write_mem(7'd42, 8'h33);
    write_mem(7'd43, 8'h44); write_mem(7'd44, 8'h77);
    launch(2'd1, 7'd40, 8'd5, 1'b0);
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid busy before rst", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst busy", busy_o, 0); check("mid rst done", done_o, 0);
    check("mid rst step", step_o, 0); check("mid rst drive", drive_o, 0);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_o || busy_o) saw = 1'b1;
    end
    check("mid rst no done", saw, 0);

    // A write attempted while busy must not reach the vector memory.
    launch(2'd1, 7'd40, 8'd5, 1'b0);
    run_to_done(2, dc);
    check("prot done_cyc", dc, 7);
    check("prot pass", pass_o, 1);
    @(negedge clk);
    mem_addr_i = 7'd42;
    @(negedge clk); @(negedge clk);
    check("prot readback", mem_data_o, 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
